aes_key_expand_128: RTL

- Iterative AES-128 key-expansion stage that feeds the round pipeline's iKeyValue inputs.
- Accepts a 128-bit cipher key on a start pulse and computes round keys 1..10 at one per clock.
- Holds all 11 round keys in an internal register file.
- Serves them through a registered read port indexed by round number.

---
 rtl/aes_key_expand_128_pkg.sv | 46 ++++
 rtl/aes_key_expand_128_sbox.sv | 32 +++
 rtl/aes_key_expand_128.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/aes_key_expand_128_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helper for the AES-128 key path.
// Used by the key-expansion top and by the S-box sub-module.
package aes_key_expand_128_pkg;

    localparam int AES_NUM_ROUNDS = 10;
    localparam int KEY_W          = 128;
    localparam int WORD_W         = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_DONE
    } state_t;

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_key_expand_128_sbox.sv
// Combinational AES S-box: multiplicative inverse (x^254) then affine map.
// Shared by SubWord in key expansion and by the SubBytes stage.
module aes_sbox
    import aes_key_expand_128_pkg::*;
(
    input  logic [7:0] data,
    output logic [7:0] sub
);

    logic [7:0] p2, p4, p8, p16, p32, p64, p128;
    logic [7:0] inv;

    // Inverse via square chain (0 maps to 0), then FIPS affine transform
    always_comb begin
        p2   = gf_mul(data, data);
        p4   = gf_mul(p2, p2);
        p8   = gf_mul(p4, p4);
        p16  = gf_mul(p8, p8);
        p32  = gf_mul(p16, p16);
        p64  = gf_mul(p32, p32);
        p128 = gf_mul(p64, p64);
        inv  = gf_mul(gf_mul(gf_mul(p2, p4), gf_mul(p8, p16)),
                      gf_mul(gf_mul(p32, p64), p128));
        sub  = inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
    end

endmodule

// File: rtl/aes_key_expand_128.sv
// Iterative AES-128 key expansion: one round key per clock into an 11-slot file.
// Optional AES_KEY_STREAM_OUT_EN adds a per-write key stream output.
module aes_key_expand_128
    import aes_key_expand_128_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iKeyStart,
    input  logic [KEY_W-1:0] iKey,
    input  logic [3:0]       iRoundSel,
    output logic [KEY_W-1:0] oKeyValue,
    output logic             oBusy,
    output logic             oKeyReady
`ifdef AES_KEY_STREAM_OUT_EN
    ,
    output logic             oStreamValid,
    output logic [3:0]       oStreamIdx,
    output logic [KEY_W-1:0] oStreamKey
`endif
);

    state_t state_q, state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_m1;
    logic [KEY_W-1:0] slot_q [0:NUM_ROUNDS];
    logic [KEY_W-1:0] prev;
    logic [KEY_W-1:0] rd_key;
    logic [KEY_W-1:0] next_key;
    logic [WORD_W-1:0] rot, subw, t;
    logic [WORD_W-1:0] n0, n1, n2, n3;
    logic start_ok, step, last;

    assign cnt_m1 = cnt_q - 4'd1;

    // Previous-slot and read-port muxes; unmatched index yields zero
    always_comb begin
        prev   = '0;
        rd_key = '0;
        for (int i = 0; i <= NUM_ROUNDS; i++) begin
            if (cnt_m1 == 4'(i))    prev   = slot_q[i];
            if (iRoundSel == 4'(i)) rd_key = slot_q[i];
        end
    end

    assign rot = {prev[23:0], prev[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .data (rot[8*b +: 8]),
            .sub  (subw[8*b +: 8])
        );
    end

    // One key-schedule round from the previous slot
    always_comb begin
        t        = subw ^ {rcon(cnt_q), 24'h0};
        n0       = prev[127:96] ^ t;
        n1       = prev[95:64]  ^ n0;
        n2       = prev[63:32]  ^ n1;
        n3       = prev[31:0]   ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state; a start during EXPAND is deliberately ignored
    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        step     = 1'b0;
        last     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (iKeyStart) begin
                    state_d  = ST_EXPAND;
                    start_ok = 1'b1;
                end
            end
            ST_EXPAND: begin
                step = 1'b1;
                if (cnt_q == 4'(NUM_ROUNDS)) begin
                    state_d = ST_DONE;
                    last    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Key storage, counter, status flags and registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= 4'd0;
            oKeyValue <= '0;
            oBusy     <= 1'b0;
            oKeyReady <= 1'b0;
            for (int i = 0; i <= NUM_ROUNDS; i++) slot_q[i] <= '0;
`ifdef AES_KEY_STREAM_OUT_EN
            oStreamValid <= 1'b0;
            oStreamIdx   <= 4'd0;
            oStreamKey   <= '0;
`endif
        end else begin
            oKeyValue <= rd_key;
`ifdef AES_KEY_STREAM_OUT_EN
            oStreamValid <= 1'b0;
`endif
            if (start_ok) begin
                slot_q[0] <= iKey;
                cnt_q     <= 4'd1;
                oBusy     <= 1'b1;
                oKeyReady <= 1'b0;
`ifdef AES_KEY_STREAM_OUT_EN
                oStreamValid <= 1'b1;
                oStreamIdx   <= 4'd0;
                oStreamKey   <= iKey;
`endif
            end else if (step) begin
                for (int i = 1; i <= NUM_ROUNDS; i++) begin
                    if (cnt_q == 4'(i)) slot_q[i] <= next_key;
                end
                cnt_q <= cnt_q + 4'd1;
`ifdef AES_KEY_STREAM_OUT_EN
                oStreamValid <= 1'b1;
                oStreamIdx   <= cnt_q;
                oStreamKey   <= next_key;
`endif
                if (last) begin
                    oBusy     <= 1'b0;
                    oKeyReady <= 1'b1;
                end
            end
        end
    end

endmodule
